// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the priority scan encoder.
package prio_scan_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // True when at most one bit of vec is set (clearing the lowest set bit leaves zero).
  function automatic logic onehot_or_zero(input logic [MAX_WIDTH-1:0] vec);
    return ((vec & (vec - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: lowest or highest set index of vec, plus a nonzero flag.
module prio_enc #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  // Ascending scan: first hit wins for LSB-first, last hit wins for MSB-first.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = (vec[i] && (MSB_FIRST || !any)) ? IDXW'(i) : idx;
      any = any | vec[i];
    end
  end

endmodule

// File: rtl/prio_scan_encoder.sv
// Accepts a request vector and streams the index of each set bit, one per handshake, in priority order.
module prio_scan_encoder
  import prio_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             none,
  output logic             busy
);

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] pending_r, next_pending_s;
  logic             none_r, next_none_s;
  logic [IDXW-1:0]  enc_idx_s;
  logic             enc_any_s;
  logic [WIDTH-1:0] clr_mask_s;
  logic             out_valid_s, out_last_s, in_ready_s;
  logic             in_hs_s, out_hs_s, in_nonzero_s;

  prio_enc #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .vec (pending_r),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  assign out_valid_s  = (state_r == SCAN);
  assign out_last_s   = out_valid_s & enc_any_s & onehot_or_zero(MAX_WIDTH'(pending_r));
  assign out_hs_s     = out_valid_s & out_ready;
  assign in_ready_s   = (state_r == IDLE) | (out_hs_s & out_last_s);
  assign in_hs_s      = in_valid & in_ready_s;
  assign in_nonzero_s = (in_vec != '0);

  // One-hot mask of the bit being retired on this beat.
  always_comb begin
    clr_mask_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr_mask_s[i] = (enc_idx_s == IDXW'(i));
    end
  end

  // Next-state, pending and none-pulse logic; flush overrides every handshake.
  always_comb begin
    next_state_s   = state_r;
    next_pending_s = pending_r;
    next_none_s    = 1'b0;
    if (flush) begin
      next_state_s   = IDLE;
      next_pending_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_hs_s && in_nonzero_s) begin
            next_state_s   = SCAN;
            next_pending_s = in_vec;
          end else if (in_hs_s) begin
            next_none_s = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end
        SCAN: begin
          if (out_hs_s && out_last_s) begin
            next_state_s   = IDLE;
            next_pending_s = '0;
            if (in_hs_s && in_nonzero_s) begin
              next_state_s   = SCAN;
              next_pending_s = in_vec;
            end else if (in_hs_s) begin
              next_none_s = 1'b1;
            end else begin
              next_state_s = IDLE;
            end
          end else if (out_hs_s) begin
            next_pending_s = pending_r & ~clr_mask_s;
          end else begin
            next_state_s = SCAN;
          end
        end
        default: begin
          next_state_s   = IDLE;
          next_pending_s = '0;
        end
      endcase
    end
  end

  // State, pending vector and zero-vector pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= '0;
      none_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      pending_r <= next_pending_s;
      none_r    <= next_none_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_idx   = out_valid_s ? enc_idx_s : '0;
  assign out_last  = out_last_s;
  assign none      = none_r;
  assign busy      = out_valid_s;

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Scoreboard bench: three encoder configurations, expected beats queued at input acceptance.
module tb_prio_scan_encoder;

  typedef struct packed {
    logic       is_none;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_s = 1'b0;
  logic       in_valid_s = 1'b0;
  logic [7:0] in_vec_s = 8'h00;
  logic       out_ready_s = 1'b1;
  int         sel = 0;

  logic       rdy_a, val_a, last_a, none_a, busy_a;
  logic       rdy_b, val_b, last_b, none_b, busy_b;
  logic       rdy_c, val_c, last_c, none_c, busy_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       mon_ready, mon_valid, mon_last, mon_none, mon_busy;
  logic [2:0] mon_idx;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_s),
    .in_valid(in_valid_s && sel == 0), .in_ready(rdy_a), .in_vec(in_vec_s),
    .out_valid(val_a), .out_ready(out_ready_s), .out_idx(idx_a),
    .out_last(last_a), .none(none_a), .busy(busy_a));

  prio_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_s),
    .in_valid(in_valid_s && sel == 1), .in_ready(rdy_b), .in_vec(in_vec_s),
    .out_valid(val_b), .out_ready(out_ready_s), .out_idx(idx_b),
    .out_last(last_b), .none(none_b), .busy(busy_b));

  prio_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_s),
    .in_valid(in_valid_s && sel == 2), .in_ready(rdy_c), .in_vec(in_vec_s[4:0]),
    .out_valid(val_c), .out_ready(out_ready_s), .out_idx(idx_c),
    .out_last(last_c), .none(none_c), .busy(busy_c));

  assign mon_ready = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
  assign mon_valid = (sel == 0) ? val_a  : (sel == 1) ? val_b  : val_c;
  assign mon_idx   = (sel == 0) ? idx_a  : (sel == 1) ? idx_b  : idx_c;
  assign mon_last  = (sel == 0) ? last_a : (sel == 1) ? last_b : last_c;
  assign mon_none  = (sel == 0) ? none_a : (sel == 1) ? none_b : none_c;
  assign mon_busy  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: walk the set bits of v in priority order for the given width.
  function automatic void push_vec(input logic [7:0] v, input int w, input bit msb);
    int   cnt = 0;
    int   seen = 0;
    exp_t e;
    for (int i = 0; i < w; i++) cnt += int'(v[i]);
    if (cnt == 0) begin
      e = '{is_none: 1'b1, idx: 3'd0, last: 1'b0};
      q.push_back(e);
    end else begin
      for (int k = 0; k < w; k++) begin
        int b = msb ? (w - 1 - k) : k;
        if (v[b]) begin
          seen++;
          e = '{is_none: 1'b0, idx: 3'(b), last: (seen == cnt)};
          q.push_back(e);
        end
      end
    end
  endfunction

  // Output monitor: every beat and every none pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!mon_valid) chk("idx_zero_when_idle", {29'd0, mon_idx}, 32'd0);
      if (mon_none) begin
        if (q.size() == 0) chk("unexpected_none", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("none_slot", {31'd0, e.is_none}, 32'd1);
        end
      end
      if (mon_valid && out_ready_s && !flush_s) begin
        if (q.size() == 0) chk("unexpected_beat", {29'd0, mon_idx}, 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          chk("beat_slot", {31'd0, e.is_none}, 32'd0);
          chk("out_idx", {29'd0, mon_idx}, {29'd0, e.idx});
          chk("out_last", {31'd0, mon_last}, {31'd0, e.last});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer v now (caller sits at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic [7:0] v, input bit model);
    int n = 0;
    in_valid_s = 1'b1;
    in_vec_s   = v;
    while (!mon_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_in_time", {31'd0, (n < 50)}, 32'd1);
    if (model) push_vec(v, (sel == 2) ? 5 : 8, (sel == 1));
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    chk("drain_in_time", {31'd0, (n < 100)}, 32'd1);
    idle(2);
  endtask

  initial begin
    #3;
    chk("rst_valid", {31'd0, mon_valid}, 32'd0);
    chk("rst_busy", {31'd0, mon_busy}, 32'd0);
    chk("rst_last", {31'd0, mon_last}, 32'd0);
    chk("rst_none", {31'd0, mon_none}, 32'd0);
    chk("rst_idx", {29'd0, mon_idx}, 32'd0);
    #10 rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", {31'd0, mon_ready}, 32'd1);

    sel = 0;
    send(8'b1010_0110, 1'b1);
    chk("first_beat_latency", {31'd0, mon_valid}, 32'd1);
    drain();

    sel = 1;
    send(8'b1010_0110, 1'b1);
    drain();

    sel = 0;
    send(8'h00, 1'b1);
    chk("zero_no_valid", {31'd0, mon_valid}, 32'd0);
    chk("zero_in_ready", {31'd0, mon_ready}, 32'd1);
    drain();

    out_ready_s = 1'b0;
    send(8'h81, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, mon_valid}, 32'd1);
      chk("stall_idx", {29'd0, mon_idx}, 32'd0);
      chk("stall_last", {31'd0, mon_last}, 32'd0);
      idle(1);
    end
    out_ready_s = 1'b1;
    drain();

    send(8'h10, 1'b1);
    in_valid_s = 1'b1;
    in_vec_s   = 8'h03;
    #1;
    chk("b2b_ready_last", {31'd0, mon_ready}, 32'd1);
    send(8'h03, 1'b1);
    chk("b2b_no_gap", {31'd0, mon_valid}, 32'd1);
    chk("b2b_first_idx", {29'd0, mon_idx}, 32'd0);
    drain();

    send(8'hF8, 1'b0);
    q.push_back('{is_none: 1'b0, idx: 3'd3, last: 1'b0});
    idle(1);
    flush_s = 1'b1;
    idle(1);
    flush_s = 1'b0;
    chk("flush_valid", {31'd0, mon_valid}, 32'd0);
    chk("flush_busy", {31'd0, mon_busy}, 32'd0);
    chk("flush_in_ready", {31'd0, mon_ready}, 32'd1);
    idle(4);
    chk("flush_no_beats", {31'd0, mon_valid}, 32'd0);
    chk("flush_queue", q.size(), 32'd0);

    out_ready_s = 1'b0;
    send(8'hF8, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, mon_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, mon_busy}, 32'd0);
    chk("rstmid_idx", {29'd0, mon_idx}, 32'd0);
    idle(1);
    rst_n = 1'b1;
    out_ready_s = 1'b1;
    idle(4);
    chk("rstmid_no_beats", {31'd0, mon_valid}, 32'd0);

    sel = 2;
    send(8'b0001_0001, 1'b1);
    drain();
    send(8'b0001_1010, 1'b1);
    drain();

    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
